htu_req_arb: RTL and testbench

- Round-robin arbiter and output register slice in front of the HTU pipeline's upstream bank-request port.
- Shares the single HTU bank-request port among NumCh requesting channels, for example the load, store and writeback-buffer paths of one bank.
- Tags each granted request with a one-hot channel id and registers it, so the HTU pipe sees a stable valid/ready source.
- Keeps a saturating per-channel grant counter for performance monitoring.

---
 rtl/htu_req_arb.sv | 163 ++++++++++++++++
 tb/tb_htu_req_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/htu_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : htu_req_arb
// Purpose  : Round-robin arbiter plus output register slice feeding the HTU
//            upstream bank-request port, with saturating per-channel grant
//            counters.
// Revision : 1.0
// ============================================================================
module htu_req_arb #(
  parameter int NUM_CH     = 3,
  parameter int WBUF_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_en,
  input  logic [NUM_CH-1:0]                req_valid,
  output logic [NUM_CH-1:0]                req_ready,
  input  logic [NUM_CH*32-1:0]             req_addr,
  input  logic [NUM_CH*3-1:0]              req_op,
  input  logic [NUM_CH*WBUF_WIDTH-1:0]     req_wbuf_id,
  output logic                             d_bank_req_valid,
  input  logic                             d_bank_req_ready,
  output logic [31:0]                      d_bank_req_addr,
  output logic [2:0]                       d_bank_req_op,
  output logic [NUM_CH-1:0]                d_bank_req_channel_1hot_id,
  output logic [WBUF_WIDTH-1:0]            d_bank_req_wbuf_id,
  input  logic                             cnt_clr,
  output logic [NUM_CH*CNT_WIDTH-1:0]      grant_cnt
);

  localparam int                 PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                 SUM_W   = PTR_W + 1;
  localparam logic [SUM_W-1:0]   C_NCH   = SUM_W'(NUM_CH);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   valid_q, valid_d;
  logic [31:0]            addr_q, addr_d;
  logic [2:0]             op_q, op_d;
  logic [NUM_CH-1:0]      id_q, id_d;
  logic [WBUF_WIDTH-1:0]  wbuf_q, wbuf_d;

  logic [NUM_CH-1:0]      elig;
  logic [NUM_CH-1:0]      grant;
  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_found;
  logic [SUM_W-1:0]       search_pos;
  logic [SUM_W-1:0]       ptr_inc;
  logic                   slot_free;
  logic                   accept;

  logic [31:0]            sel_addr;
  logic [2:0]             sel_op;
  logic [WBUF_WIDTH-1:0]  sel_wbuf;

  assign elig      = req_valid & ch_en;
  assign slot_free = !valid_q | d_bank_req_ready;
  assign accept    = slot_free & (|grant);
  assign req_ready = (slot_free && !rst) ? grant : '0;

  // Rotating priority search starting at ptr_q, wrapping modulo NUM_CH.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    search_pos  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      search_pos = {1'b0, ptr_q} + SUM_W'(k);
      if (search_pos >= C_NCH) begin
        search_pos = search_pos - C_NCH;
      end
      if (!grant_found && elig[search_pos[PTR_W-1:0]]) begin
        grant[search_pos[PTR_W-1:0]] = 1'b1;
        grant_idx                    = search_pos[PTR_W-1:0];
        grant_found                  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_op   = '0;
    sel_wbuf = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*32 +: 32];
        sel_op   = sel_op   | req_op[i*3 +: 3];
        sel_wbuf = sel_wbuf | req_wbuf_id[i*WBUF_WIDTH +: WBUF_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    op_d    = op_q;
    id_d    = id_q;
    wbuf_d  = wbuf_q;
    ptr_inc = {1'b0, grant_idx} + SUM_W'(1);
    if (accept) begin
      valid_d = 1'b1;
      addr_d  = sel_addr;
      op_d    = sel_op;
      id_d    = grant;
      wbuf_d  = sel_wbuf;
      ptr_d   = (ptr_inc == C_NCH) ? '0 : ptr_inc[PTR_W-1:0];
    end else if (valid_q && d_bank_req_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      op_q    <= '0;
      id_q    <= '0;
      wbuf_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      id_q    <= id_d;
      wbuf_q  <= wbuf_d;
    end
  end

  assign d_bank_req_valid           = valid_q;
  assign d_bank_req_addr            = addr_q;
  assign d_bank_req_op              = op_q;
  assign d_bank_req_channel_1hot_id = id_q;
  assign d_bank_req_wbuf_id         = wbuf_q;

  // Clear wins over a same-cycle increment.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
        cnt_d = '0;
      end else if (accept && grant[gi] && (cnt_q != C_CNT_MAX)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_htu_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_htu_req_arb
// Purpose  : Scoreboard bench for htu_req_arb (3 channels, 2-bit counters).
// Revision : 1.0
// ============================================================================
module tb_htu_req_arb;

  localparam int N  = 3;
  localparam int WW = 4;
  localparam int CW = 2;

  typedef struct {
    logic [31:0]   addr;
    logic [2:0]    op;
    logic [N-1:0]  id;
    logic [WW-1:0] wbuf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      ch_en;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_addr;
  logic [N*3-1:0]    req_op;
  logic [N*WW-1:0]   req_wbuf_id;
  logic              d_bank_req_valid;
  logic              d_bank_req_ready;
  logic [31:0]       d_bank_req_addr;
  logic [2:0]        d_bank_req_op;
  logic [N-1:0]      d_bank_req_channel_1hot_id;
  logic [WW-1:0]     d_bank_req_wbuf_id;
  logic              cnt_clr;
  logic [N*CW-1:0]   grant_cnt;

  htu_req_arb #(.NUM_CH(N), .WBUF_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .ch_en                      (ch_en),
    .req_valid                  (req_valid),
    .req_ready                  (req_ready),
    .req_addr                   (req_addr),
    .req_op                     (req_op),
    .req_wbuf_id                (req_wbuf_id),
    .d_bank_req_valid           (d_bank_req_valid),
    .d_bank_req_ready           (d_bank_req_ready),
    .d_bank_req_addr            (d_bank_req_addr),
    .d_bank_req_op              (d_bank_req_op),
    .d_bank_req_channel_1hot_id (d_bank_req_channel_1hot_id),
    .d_bank_req_wbuf_id         (d_bank_req_wbuf_id),
    .cnt_clr                    (cnt_clr),
    .grant_cnt                  (grant_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   ch_addr [N];
  logic [2:0]    ch_op   [N];
  logic [WW-1:0] ch_wbuf [N];

  int          m_ptr;
  logic        m_valid;
  int          m_cnt [N];
  exp_t        sb_q [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic new_data(input int c);
    ch_addr[c] = $urandom;
    ch_op[c]   = 3'($urandom);
    ch_wbuf[c] = WW'($urandom);
  endtask

  // One clock: drive at +1 after posedge, check at negedge, advance model at posedge.
  task automatic cyc(input logic r, input logic [N-1:0] en, input logic [N-1:0] v,
                     input logic dr, input logic clr);
    logic [N-1:0] elig, gnt, exp_rdy;
    int           gi;
    logic         slot_free, acc;
    exp_t         e;
    rst = r; ch_en = en; req_valid = v; d_bank_req_ready = dr; cnt_clr = clr;
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32]  = ch_addr[i];
      req_op[i*3 +: 3]      = ch_op[i];
      req_wbuf_id[i*WW +: WW] = ch_wbuf[i];
    end
    elig = v & en;
    gnt  = '0;
    gi   = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (gi < 0 && elig[idx]) begin
        gi = idx;
        gnt[idx] = 1'b1;
      end
    end
    slot_free = !m_valid || dr;
    exp_rdy   = (slot_free && !r) ? gnt : '0;

    @(negedge clk);
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("out_valid", 64'(d_bank_req_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        check_eq("out_addr", 64'(d_bank_req_addr), 64'(sb_q[0].addr));
        check_eq("out_op",   64'(d_bank_req_op),   64'(sb_q[0].op));
        check_eq("out_id",   64'(d_bank_req_channel_1hot_id), 64'(sb_q[0].id));
        check_eq("out_wbuf", 64'(d_bank_req_wbuf_id), 64'(sb_q[0].wbuf));
      end
    end
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("grant_cnt%0d", i), 64'(grant_cnt[i*CW +: CW]), 64'(m_cnt[i]));
    end

    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      sb_q.delete();
    end else begin
      acc = slot_free && (gi >= 0);
      if (m_valid && dr && sb_q.size() != 0) void'(sb_q.pop_front());
      if (acc) begin
        e.addr = ch_addr[gi]; e.op = ch_op[gi]; e.id = gnt; e.wbuf = ch_wbuf[gi];
        sb_q.push_back(e);
        m_valid = 1'b1;
        m_ptr   = (gi + 1) % N;
        if (m_cnt[gi] < (1 << CW) - 1) m_cnt[gi]++;
        new_data(gi);
      end else if (m_valid && dr) begin
        m_valid = 1'b0;
      end
      if (clr) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
    end
    #1;
  endtask

  initial begin
    m_ptr = 0; m_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      new_data(i);
    end
    rst = 1'b1; ch_en = '0; req_valid = '0; d_bank_req_ready = 1'b0; cnt_clr = 1'b0;
    req_addr = '0; req_op = '0; req_wbuf_id = '0;
    @(posedge clk);
    #1;
    cyc(1'b1, 3'b111, 3'b111, 1'b1, 1'b0);
    check_eq("rst_addr", 64'(d_bank_req_addr), 64'd0);
    check_eq("rst_op",   64'(d_bank_req_op),   64'd0);
    check_eq("rst_id",   64'(d_bank_req_channel_1hot_id), 64'd0);
    check_eq("rst_wbuf", 64'(d_bank_req_wbuf_id), 64'd0);

    // Full round robin with ready held high
    repeat (7) cyc(1'b0, 3'b111, 3'b111, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 3'b111, 3'b000, 1'b1, 1'b0);

    // Lone channel 2 request with known fields
    ch_addr[2] = 32'h8000_1040; ch_op[2] = 3'd3; ch_wbuf[2] = 4'd5;
    cyc(1'b0, 3'b111, 3'b100, 1'b1, 1'b0);
    check_eq("ch2_addr", 64'(d_bank_req_addr), 64'h8000_1040);
    check_eq("ch2_id",   64'(d_bank_req_channel_1hot_id), 64'b100);
    cyc(1'b0, 3'b111, 3'b000, 1'b1, 1'b0);

    // Stall with channels 1 and 2 waiting behind a registered channel 0
    cyc(1'b0, 3'b111, 3'b001, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 3'b111, 3'b110, 1'b0, 1'b0);
    cyc(1'b0, 3'b111, 3'b110, 1'b1, 1'b0);
    check_eq("post_stall_id", 64'(d_bank_req_channel_1hot_id), 64'b010);
    repeat (2) cyc(1'b0, 3'b111, 3'b000, 1'b1, 1'b0);

    // Channel 1 disabled
    repeat (6) cyc(1'b0, 3'b101, 3'b111, 1'b1, 1'b0);
    cyc(1'b0, 3'b111, 3'b000, 1'b1, 1'b1);

    // Counter saturation on channel 0
    repeat (5) cyc(1'b0, 3'b111, 3'b001, 1'b1, 1'b0);
    // Clear coincident with an accept
    cyc(1'b0, 3'b111, 3'b001, 1'b1, 1'b1);
    cyc(1'b0, 3'b111, 3'b000, 1'b1, 1'b0);

    // Reset while stalled
    cyc(1'b0, 3'b111, 3'b010, 1'b1, 1'b0);
    cyc(1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 3'b111, 3'b111, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 3'b111, 3'b111, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 63) == 0), 3'($urandom), 3'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
